// File: rtl/alu_operand_regfile.sv
// alu_operand_regfile: operand register file feeding the ALU A/B buses.
//   - Two combinational read ports, one synchronous write port.
//   - After reset a sequencer zeroes one entry per clock (busy high meanwhile).
//   - Address PC_REG has no storage; reads of it return pc_in.
// Optional build macro: ALU_OPERAND_REGFILE_BYPASS_EN
//   When defined, a RUN-state write to address A is forwarded combinationally
//   to any read port addressing A in the same cycle.
module alu_operand_regfile #(
  parameter int W      = 32,
  parameter int ADDR_W = 4,
  parameter int PC_REG = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [W-1:0]      wd,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  input  logic [W-1:0]      pc_in,
  output logic [W-1:0]      rd1,
  output logic [W-1:0]      rd2,
  output logic              busy
);

  localparam int                N_REGS   = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] PC_ADDR  = ADDR_W'(PC_REG);
  localparam logic [ADDR_W-1:0] CNT_LAST = ADDR_W'(N_REGS - 1);

  // Write-port handshake: a write is accepted on a rising edge only when
  // we is high, the sequencer is in RUN and wa is not the PC alias. There is
  // no back-pressure; busy tells the producer that writes are being dropped.

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]      mem_q [N_REGS];
  logic              wr_en;

  // Next state of the clear sequencer: walk every entry once, then run.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_CLEAR) begin
      cnt_d = cnt_q + 1'b1;  // wraps to 0 on the last step
      if (cnt_q == CNT_LAST) begin
        state_d = ST_RUN;
      end
    end
  end

  // Sequencer state; reset restarts the clear from entry 0 immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy  = (state_q == ST_CLEAR);
  assign wr_en = (state_q == ST_RUN) && we && (wa != PC_ADDR);

  // Array update: clear one entry per edge in CLEAR, normal writes in RUN.
  // The array itself has no reset; the sequencer is what zeroes it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state_q == ST_CLEAR) begin
        mem_q[cnt_q] <= '0;
      end else if (wr_en) begin
        mem_q[wa] <= wd;
      end
    end
  end

  // One read port's value; CLEAR forces zero so stale array contents never leak.
  function automatic logic [W-1:0] read_port(input logic [ADDR_W-1:0] ra);
    logic [W-1:0] val;
    val = '0;
    if (state_q == ST_RUN) begin
      if (ra == PC_ADDR) begin
        val = pc_in;
`ifdef ALU_OPERAND_REGFILE_BYPASS_EN
      end else if (wr_en && (ra == wa)) begin
        val = wd;
`endif
      end else begin
        val = mem_q[ra];
      end
    end
    return val;
  endfunction

  // Port 1 read (ALU A operand), zero latency.
  always_comb begin
    rd1 = read_port(ra1);
  end

  // Port 2 read (ALU B operand), zero latency.
  always_comb begin
    rd2 = read_port(ra2);
  end

endmodule

// File: tb/tb_alu_operand_regfile.sv
// Testbench for alu_operand_regfile: directed vector table, hand-written
// clear/reset sequences and a randomized run against a behavioural model.
module tb_alu_operand_regfile;

`ifdef ALU_OPERAND_REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic [3:0]  wa;
  logic [31:0] wd;
  logic [3:0]  ra1, ra2;
  logic [31:0] pc_in;
  logic [31:0] rd1, rd2;
  logic        busy;

  always #5 clk = ~clk;

  alu_operand_regfile #(.W(32), .ADDR_W(4), .PC_REG(15)) dut (
    .clk   (clk),
    .reset (reset),
    .we    (we),
    .wa    (wa),
    .wd    (wd),
    .ra1   (ra1),
    .ra2   (ra2),
    .pc_in (pc_in),
    .rd1   (rd1),
    .rd2   (rd2),
    .busy  (busy)
  );

  // ---------------- reference model ----------------
  // Register contents as a plain array, plus how many clear edges remain.
  logic [31:0] m_mem [16];
  int          clear_left;
  int          clear_idx;

  int n_cmp  = 0;
  int n_fail = 0;

  function automatic logic [31:0] exp_rd(input logic [3:0] ra);
    if (clear_left > 0) return 32'h0;
    if (ra == 4'd15) return pc_in;
    if (BYP && we && (wa != 4'd15) && (ra == wa)) return wd;
    return m_mem[ra];
  endfunction

  task automatic model_reset();
    clear_left = 16;
    clear_idx  = 0;
  endtask

  task automatic model_edge();
    if (clear_left > 0) begin
      m_mem[clear_idx] = 32'h0;
      clear_idx++;
      clear_left--;
    end else if (we && (wa != 4'd15)) begin
      m_mem[wa] = wd;
    end
  endtask

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, "_rd1"},  rd1, exp_rd(ra1));
    check({tag, "_rd2"},  rd2, exp_rd(ra2));
    check({tag, "_busy"}, {31'b0, busy}, {31'b0, (clear_left > 0)});
  endtask

  // ---------------- driver tasks ----------------
  // Advance one rising edge; the model consumes the same inputs the DUT sees.
  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic w, input logic [3:0] a, input logic [31:0] d,
                       input logic [3:0] r1, input logic [3:0] r2, input logic [31:0] pc);
    we = w; wa = a; wd = d; ra1 = r1; ra2 = r2; pc_in = pc;
  endtask

  // Asynchronous reset pulse placed between edges; outputs must react with no clock.
  task automatic async_reset_pulse(input string tag);
    reset = 1'b1;
    model_reset();
    #1;
    check({tag, "_async_busy"}, {31'b0, busy}, 32'h1);
    check({tag, "_async_rd1"}, rd1, 32'h0);
    check({tag, "_async_rd2"}, rd2, 32'h0);
    #2;
    reset = 1'b0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        we;
    logic [3:0]  wa;
    logic [31:0] wd;
    logic [3:0]  ra1;
    logic [3:0]  ra2;
    logic [31:0] pc;
    logic [31:0] e1;
    logic [31:0] e2;
  } vec_t;

  vec_t vecs [9];

  initial begin
    // Table assumes an all-zero array in RUN when it starts.
    vecs[0] = '{1'b1, 4'd5,  32'h0000_00AA, 4'd0,  4'd0,  32'h0,          32'h0,          32'h0};
    vecs[1] = '{1'b0, 4'd0,  32'h0,         4'd5,  4'd5,  32'h0,          32'h0000_00AA,  32'h0000_00AA};
    vecs[2] = '{1'b0, 4'd0,  32'h0,         4'd5,  4'd15, 32'h0000_0108,  32'h0000_00AA,  32'h0000_0108};
    vecs[3] = '{1'b1, 4'd15, 32'h1234_5678, 4'd15, 4'd5,  32'h0,          32'h0,          32'h0000_00AA};
    vecs[4] = '{1'b0, 4'd0,  32'h0,         4'd15, 4'd0,  32'h0,          32'h0,          32'h0};
    vecs[5] = '{1'b1, 4'd7,  32'hFFFF_FFFF, 4'd7,  4'd1,  32'h0,
                (BYP ? 32'hFFFF_FFFF : 32'h0), 32'h0};
    vecs[6] = '{1'b0, 4'd0,  32'h0,         4'd7,  4'd7,  32'h0,          32'hFFFF_FFFF,  32'hFFFF_FFFF};
    vecs[7] = '{1'b1, 4'd7,  32'h0000_0001, 4'd5,  4'd7,  32'h0,
                32'h0000_00AA, (BYP ? 32'h0000_0001 : 32'hFFFF_FFFF)};
    vecs[8] = '{1'b0, 4'd0,  32'h0,         4'd7,  4'd14, 32'h0000_DEAD,  32'h0000_0001,  32'h0};

    for (int i = 0; i < 16; i++) m_mem[i] = 32'h0;
    clear_left = 16;
    clear_idx  = 0;

    // ---- reset state ----
    reset = 1'b1;
    drive(1'b0, 4'd0, 32'h0, 4'd3, 4'd15, 32'h0000_0108);
    @(posedge clk);
    #1;
    check("rst_busy", {31'b0, busy}, 32'h1);
    check("rst_rd1", rd1, 32'h0);
    check("rst_rd2", rd2, 32'h0);
    reset = 1'b0;
    model_reset();

    // ---- clear sequence with writes attempted ----
    drive(1'b1, 4'd3, 32'hDEAD_BEEF, 4'd3, 4'd15, 32'h0000_0108);
    for (int k = 0; k < 16; k++) begin
      #1;
      check("clr_busy", {31'b0, busy}, 32'h1);
      check("clr_rd1", rd1, 32'h0);
      check("clr_rd2", rd2, 32'h0);
      tick();
    end
    we = 1'b0;
    #1;
    check("clr_done_busy", {31'b0, busy}, 32'h0);
    check("clr_drop_rd1", rd1, 32'h0);
    check("clr_pc_rd2", rd2, 32'h0000_0108);

    // ---- table-driven RUN vectors ----
    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].ra1, vecs[i].ra2, vecs[i].pc);
      #1;
      check($sformatf("vec%0d_rd1", i), rd1, vecs[i].e1);
      check($sformatf("vec%0d_rd2", i), rd2, vecs[i].e2);
      check($sformatf("vec%0d_busy", i), {31'b0, busy}, 32'h0);
      tick();
    end

    // ---- fill all writable entries, read back ----
    for (int i = 0; i < 15; i++) begin
      drive(1'b1, 4'(i), i * 32'h0101_0101, 4'd0, 4'd15, 32'h0);
      tick();
    end
    for (int i = 0; i < 15; i++) begin
      drive(1'b0, 4'd0, 32'h0, 4'(i), 4'(14 - i), 32'h0000_4000);
      #1;
      check("fill_rd1", rd1, i * 32'h0101_0101);
      check("fill_rd2", rd2, (14 - i) * 32'h0101_0101);
      tick();
    end

    // ---- restart clear, interrupt it at step 6, let it complete ----
    drive(1'b0, 4'd0, 32'h0, 4'd9, 4'd15, 32'h0000_0500);
    async_reset_pulse("clrA");
    for (int k = 0; k < 6; k++) begin
      #1;
      check_model("clrA");
      tick();
    end
    #1;
    async_reset_pulse("midclr");
    for (int k = 0; k < 16; k++) begin
      drive(1'b1, 4'($urandom_range(0, 15)), $urandom, 4'(k), 4'd15, 32'h0000_0500);
      #1;
      check_model("clrB");
      tick();
    end
    for (int i = 0; i < 15; i++) begin
      drive(1'b0, 4'd0, 32'h0, 4'(i), 4'(14 - i), 32'h0);
      #1;
      check("zero_rd1", rd1, 32'h0);
      check("zero_rd2", rd2, 32'h0);
      check("zero_busy", {31'b0, busy}, 32'h0);
      tick();
    end

    // ---- asynchronous reset from RUN with live data ----
    drive(1'b1, 4'd5, 32'h0000_00AA, 4'd0, 4'd0, 32'h0);
    tick();
    drive(1'b0, 4'd0, 32'h0, 4'd5, 4'd15, 32'h0000_0108);
    #1;
    check("run_pre_rd1", rd1, 32'h0000_00AA);
    #1;
    async_reset_pulse("run");
    for (int k = 0; k < 16; k++) begin
      #1;
      check_model("run_clr");
      tick();
    end

    // ---- randomized traffic against the model ----
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 63) == 0) async_reset_pulse("rnd");
      we    = ($urandom_range(0, 2) != 0);
      wa    = 4'($urandom_range(0, 15));
      wd    = $urandom;
      ra1   = ($urandom_range(0, 3) == 0) ? wa : 4'($urandom_range(0, 15));
      ra2   = ($urandom_range(0, 3) == 0) ? wa : 4'($urandom_range(0, 15));
      pc_in = $urandom;
      #1;
      check_model("rnd");
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
